// File: rtl/toi2s_pkg.sv
// Shared constants and helpers for the I2S transmitter: frame geometry,
// default sample width and the frame-load source selection.
package toi2s_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    LOAD_HOLD   = 2'd0,
    LOAD_BYPASS = 2'd1,
    LOAD_EMPTY  = 2'd2
  } load_sel_e;

  // A full holding buffer always wins; otherwise a pair offered in the load
  // cycle itself goes straight to the shifters.
  function automatic load_sel_e pick_load(input logic hold_full, input logic xfer);
    if (hold_full) begin
      return LOAD_HOLD;
    end else if (xfer) begin
      return LOAD_BYPASS;
    end
    return LOAD_EMPTY;
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between an audio source and the I2S transmitter.
interface i2s_tx_if
  import toi2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] sample_l;
  logic [DATA_W-1:0] sample_r;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: toggles bck every BCK_DIV clk cycles and flags the
// clk on which bck goes from 1 to 0.
module i2s_bck_gen #(
  parameter int BCK_DIV = 4
) (
  input  logic clk,
  input  logic resetb,
  input  logic clr,
  output logic bck,
  output logic fall
);

  localparam int DIV_W = $clog2(BCK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tc;

  assign tc   = (div == DIV_MAX);
  assign fall = tc && bck;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div <= '0;
      bck <= 1'b0;
    end else if (clr) begin
      div <= '0;
      bck <= 1'b0;
    end else if (tc) begin
      div <= '0;
      bck <= !bck;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter: one-deep holding buffer, 64-BCK frames,
// left/right slots of 32 BCK with MSB one BCK after the word-select edge.
module i2s_tx
  import toi2s_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BCK_DIV = 4
) (
  input  logic     clk,
  input  logic     resetb,
  input  logic     ena,
  i2s_tx_if.slave  smp,
  output logic     i2s_bck,
  output logic     i2s_ws,
  output logic     i2s_d0,
  output logic     underrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] L_FIRST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] R_FIRST  = CNT_W'(SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(SLOT_BITS + DATA_W);

  logic              fall;
  logic              load;
  logic              xfer;
  logic              alive;
  logic              hold_full;
  logic              in_l;
  logic              in_r;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_nxt;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] shift_l;
  logic [DATA_W-1:0] shift_r;

  i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
    .clk    (clk),
    .resetb (resetb),
    .clr    (!ena),
    .bck    (i2s_bck),
    .fall   (fall)
  );

  assign bit_nxt = bit_cnt + CNT_W'(1);
  assign load    = fall && (bit_cnt == LAST_BIT);
  assign in_l    = (bit_nxt >= L_FIRST) && (bit_nxt <= L_LAST);
  assign in_r    = (bit_nxt >= R_FIRST) && (bit_nxt <= R_LAST);

  // alive keeps ready low while reset is held even if ena is already high
  assign smp.sample_ready = ena && alive && !hold_full;
  assign xfer             = smp.sample_valid && smp.sample_ready;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      alive     <= 1'b0;
      bit_cnt   <= LAST_BIT;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      shift_l   <= '0;
      shift_r   <= '0;
      i2s_ws    <= 1'b0;
      i2s_d0    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      alive    <= 1'b1;
      underrun <= 1'b0;
      if (!ena) begin
        bit_cnt   <= LAST_BIT;
        hold_full <= 1'b0;
        hold_l    <= '0;
        hold_r    <= '0;
        shift_l   <= '0;
        shift_r   <= '0;
        i2s_ws    <= 1'b0;
        i2s_d0    <= 1'b0;
      end else begin
        if (load) begin
          unique case (pick_load(hold_full, xfer))
            LOAD_HOLD: begin
              shift_l   <= hold_l;
              shift_r   <= hold_r;
              hold_full <= 1'b0;
            end
            LOAD_BYPASS: begin
              shift_l <= smp.sample_l;
              shift_r <= smp.sample_r;
            end
            default: begin
              shift_l  <= '0;
              shift_r  <= '0;
              underrun <= 1'b1;
            end
          endcase
        end else if (xfer) begin
          hold_l    <= smp.sample_l;
          hold_r    <= smp.sample_r;
          hold_full <= 1'b1;
        end

        // A load edge lands on bit 0, which is neither slot, so the
        // shifters are never written twice in one cycle.
        if (fall) begin
          bit_cnt <= bit_nxt;
          i2s_ws  <= bit_nxt[CNT_W-1];
          if (in_l) begin
            i2s_d0  <= shift_l[DATA_W-1];
            shift_l <= shift_l << 1;
          end else if (in_r) begin
            i2s_d0  <= shift_r[DATA_W-1];
            shift_r <= shift_r << 1;
          end else begin
            i2s_d0 <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: cycle model plus sample-pair scoreboard checked every
// clk, a stimulus table of pairs, and hand sequences for start/abort cases.
module tb_i2s_tx;
  import toi2s_pkg::*;

  localparam int DW        = 24;
  localparam int FRAME_CLK = 512;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            gap;
  } vec_t;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic ena = 1'b0;
  logic i2s_bck, i2s_ws, i2s_d0, underrun;

  i2s_tx_if #(.DATA_W(DW)) smp_if ();

  i2s_tx #(.DATA_W(DW), .BCK_DIV(4)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .ena      (ena),
    .smp      (smp_if),
    .i2s_bck  (i2s_bck),
    .i2s_ws   (i2s_ws),
    .i2s_d0   (i2s_d0),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced once per clk at the falling clk edge
  int    n = 0;
  logic  alive_m = 1'b0;
  logic  ws_m = 1'b0;
  logic  d0_m = 1'b0;
  logic  uf_m = 1'b0;
  pair_t q[$];
  pair_t cur = '0;
  pair_t p_pair = '0;
  logic  p_rst = 1'b0;
  logic  p_ena = 1'b0;
  logic  p_xfer = 1'b0;
  logic [DW-1:0] got_l = '0;
  logic [DW-1:0] got_r = '0;
  int    dut_uf_cnt = 0;
  int    dut_xfer_cnt = 0;

  always @(negedge clk) begin : mon
    logic exp_ready;
    int   b;
    if (!resetb) begin
      n = 0; alive_m = 1'b0; ws_m = 1'b0; d0_m = 1'b0; uf_m = 1'b0;
      q.delete();
    end else if (p_rst) begin
      uf_m    = 1'b0;
      alive_m = 1'b1;
      if (!p_ena) begin
        n = 0; ws_m = 1'b0; d0_m = 1'b0;
        q.delete();
      end else begin
        if (p_xfer) q.push_back(p_pair);
        n++;
        if (n % 8 == 0) begin
          b = (n / 8 - 1) % 64;
          if (b == 0) begin
            if (q.size() > 0) begin
              cur = q.pop_front();
            end else begin
              cur  = '0;
              uf_m = 1'b1;
            end
            got_l = '0;
            got_r = '0;
          end
          ws_m = (b >= 32);
          if (b >= 1 && b <= DW) begin
            d0_m  = cur.l[DW-b];
            got_l = {got_l[DW-2:0], i2s_d0};
          end else if (b >= 33 && b <= 32 + DW) begin
            d0_m  = cur.r[32+DW-b];
            got_r = {got_r[DW-2:0], i2s_d0};
          end else begin
            d0_m = 1'b0;
          end
          if (b == 63) begin
            check("frame_left", 32'(got_l), 32'(cur.l));
            check("frame_right", 32'(got_r), 32'(cur.r));
          end
        end
      end
    end
    exp_ready = ena && alive_m && (q.size() == 0);
    check("bck", 32'(i2s_bck), 32'(((n / 4) % 2) == 1));
    check("ws", 32'(i2s_ws), 32'(ws_m));
    check("d0", 32'(i2s_d0), 32'(d0_m));
    check("underrun", 32'(underrun), 32'(uf_m));
    check("ready", 32'(smp_if.sample_ready), 32'(exp_ready));
    if (underrun) dut_uf_cnt++;
    if (smp_if.sample_valid && smp_if.sample_ready) dut_xfer_cnt++;
    p_rst  = resetb;
    p_ena  = ena;
    p_xfer = smp_if.sample_valid && exp_ready;
    p_pair = {smp_if.sample_l, smp_if.sample_r};
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit done = 1'b0;
    smp_if.sample_l     = l;
    smp_if.sample_r     = r;
    smp_if.sample_valid = 1'b1;
    for (int i = 0; i < 1200 && !done; i++) begin
      @(negedge clk);
      if (smp_if.sample_ready) done = 1'b1;
    end
    check("offer_ready", 32'(smp_if.sample_ready), 32'd1);
    @(posedge clk);
    #1;
    smp_if.sample_valid = 1'b0;
    smp_if.sample_l     = DW'($urandom);
    smp_if.sample_r     = DW'($urandom);
  endtask

  task automatic wait_phase(input int ph);
    bit found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (n % FRAME_CLK == ph) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_phase: phase %0d never reached, model count %0d", ph, n);
    end
  endtask

  task automatic startup();
    int u0 = dut_uf_cnt;
    resetb = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("start_ready", 32'(smp_if.sample_ready), 32'd1);
      if (k == 3) check("start_bck_low", 32'(i2s_bck), 32'd0);
      if (k == 4) check("start_bck_rise", 32'(i2s_bck), 32'd1);
      if (k == 7) check("start_bck_high", 32'(i2s_bck), 32'd1);
      if (k == 8) begin
        check("start_bck_fall", 32'(i2s_bck), 32'd0);
        check("start_underrun", 32'(underrun), 32'd1);
      end
    end
    tick(505);
    check("start_uf_count", 32'(dut_uf_cnt - u0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bck"}, 32'(i2s_bck), 32'd0);
    check({tag, "_ws"}, 32'(i2s_ws), 32'd0);
    check({tag, "_d0"}, 32'(i2s_d0), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_ready"}, 32'(smp_if.sample_ready), 32'd0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   u0, x0;

    vecs[0] = '{l: 24'h800001, r: 24'h7FFFFE, gap: 0};
    vecs[1] = '{l: 24'hFFFFFF, r: 24'h000000, gap: 0};
    vecs[2] = '{l: 24'h000000, r: 24'hFFFFFF, gap: 1};
    vecs[3] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, gap: 0};
    vecs[4] = '{l: 24'h123456, r: 24'hFEDCBA, gap: 0};
    vecs[5] = '{l: 24'h7FFFFF, r: 24'h800000, gap: 2};

    smp_if.sample_valid = 1'b0;
    smp_if.sample_l     = '0;
    smp_if.sample_r     = '0;
    resetb = 1'b0;
    ena    = 1'b1;
    tick(3);
    check_all_zero("reset");

    // Release with no source: one underrun, silent frame
    startup();

    // Table-driven pairs through the holding buffer
    for (int i = 0; i < 6; i++) begin
      tick(vecs[i].gap * FRAME_CLK);
      offer(vecs[i].l, vecs[i].r);
    end
    tick(3 * FRAME_CLK);

    // Valid held high: one transfer per frame, no underrun
    smp_if.sample_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      smp_if.sample_l = DW'($urandom);
      smp_if.sample_r = DW'($urandom);
    end
    u0 = dut_uf_cnt;
    x0 = dut_xfer_cnt;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      tick(1);
      smp_if.sample_l = DW'($urandom);
      smp_if.sample_r = DW'($urandom);
    end
    check("stream_xfers", 32'(dut_xfer_cnt - x0), 32'd3);
    check("stream_uf", 32'(dut_uf_cnt - u0), 32'd0);
    smp_if.sample_valid = 1'b0;
    tick(1100);

    // Bypass: valid first seen in the load cycle with holding empty
    wait_phase(6);
    u0 = dut_uf_cnt;
    smp_if.sample_l     = 24'h5A0F3C;
    smp_if.sample_r     = 24'hC3F00A;
    smp_if.sample_valid = 1'b1;
    tick(1);
    smp_if.sample_valid = 1'b0;
    smp_if.sample_l     = DW'($urandom);
    smp_if.sample_r     = DW'($urandom);
    check("bypass_underrun", 32'(underrun), 32'd0);
    check("bypass_ready", 32'(smp_if.sample_ready), 32'd1);
    tick(500);
    check("bypass_uf_count", 32'(dut_uf_cnt - u0), 32'd0);

    // Reset asserted at bit_cnt 40 of a frame carrying data
    offer(24'h3C3C3C, 24'h9ABCDE);
    wait_phase(8);
    wait_phase(330);
    check("abort_ws_before", 32'(i2s_ws), 32'd1);
    resetb = 1'b0;
    #1;
    check_all_zero("abort");
    tick(4);
    startup();

    // ena dropped for 3 clk with the holding buffer full
    wait_phase(100);
    offer(24'h456789, 24'hABCDEF);
    tick(10);
    check("hold_full_ready", 32'(smp_if.sample_ready), 32'd0);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("ena_off_ready", 32'(smp_if.sample_ready), 32'd0);
      check("ena_off_bck", 32'(i2s_bck), 32'd0);
    end
    ena = 1'b1;
    #1;
    check("ena_on_ready", 32'(smp_if.sample_ready), 32'd1);
    u0 = dut_uf_cnt;
    tick(12);
    check("ena_restart_uf", 32'(dut_uf_cnt - u0), 32'd1);
    tick(FRAME_CLK + 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_W, default 24: sample width in bits.
REQ-002 Parameter BCK_DIV, default 4: clk cycles per BCK half-period, minimum 2.
REQ-003 clk  input  1  single system clock; all logic runs on its rising edge.
REQ-004 resetb  input  1  reset, asynchronous and active-low.
REQ-005 ena  input  1  block enable.
REQ-006 sample_l  input  DATA_W  left sample, two's complement.
REQ-007 sample_r  input  DATA_W  right sample, two's complement.
REQ-008 sample_valid  input  1  sample pair offered.
REQ-009 sample_ready  output  1  holding buffer can accept a pair.
REQ-010 i2s_bck  output  1  I2S bit clock.
REQ-011 i2s_ws  output  1  word select: 0 = left, 1 = right.
REQ-012 i2s_d0  output  1  serial data, MSB first.
REQ-013 underrun  output  1  one-clk pulse when a frame starts with no sample available.

Function
REQ-014 i2s_bck shall toggle when the divider counter reaches BCK_DIV-1; the counter then wraps to 0; all outputs are registered.
REQ-015 A falling event is the clk on which i2s_bck toggles from 1 to 0; i2s_ws, i2s_d0 and bit_cnt shall change only on falling events.
REQ-016 bit_cnt (6 bits) shall increment modulo 64 on each falling event; a frame is 64 BCK periods.
REQ-017 i2s_ws shall be 0 for bit_cnt 0..31 and 1 for bit_cnt 32..63.
REQ-018 Philips format: i2s_d0 shall carry the left MSB at bit_cnt 1 and the left bits at 1..DATA_W; the right MSB at 33 and the right bits at 33..32+DATA_W; all other positions 0.
REQ-019 Frame load shall occur on the falling event that moves bit_cnt from 63 to 0; the shift registers are loaded in that cycle.
REQ-020 Load cases:
  - holding full: shift <= holding; holding becomes empty.
  - holding empty with sample_valid: bypass, shift <= inputs; holding stays empty.
  - holding empty without sample_valid: shift <= 0 and underrun = 1 for that cycle.
REQ-021 sample_ready shall equal ena AND NOT hold_full; a transfer occurs on any clk where valid and ready are both 1.
REQ-022 sample_l/sample_r are captured only at transfer; the inputs may change afterwards.
REQ-023 A transfer outside a load cycle shall set hold_full; hold_full shall never be overwritten while full.
REQ-024 ena = 0 shall act as a synchronous clear to reset values; ena rising shall restart from the reset state.

Reset
REQ-025 While resetb = 0, the block shall hold these values:
  - i2s_bck = 0, i2s_ws = 0, i2s_d0 = 0, underrun = 0.
  - divider = 0, bit_cnt = 63, hold_full = 0, shift registers = 0.
  - sample_ready = 0 (it follows ena after reset release).
REQ-026 The first falling event after reset or enable shall be a frame load.
REQ-027 Reset asserted mid-frame shall abort the frame immediately; no partial-frame completion.

Structure
REQ-028 DATA_W default and frame/slot constants (64, 32) shall live in shared package toi2s_pkg.
REQ-029 Sub-module i2s_bck_gen (divider plus falling-event strobe) is natural; serializer and handshake stay in i2s_tx.

Verification (BCK_DIV = 4, DATA_W = 24)
REQ-030 Release reset with ena = 1 and no valid: i2s_bck rises at clk 4 and falls at clk 8; the first falling event is a load, so underrun pulses once and i2s_d0 stays 0 for the whole frame.
REQ-031 Preload L = 0x800001, R = 0x7FFFFE: d0 bits 1..24 = 1000…0001, bits 33..56 = 0111…1110, all other bits 0; i2s_ws toggles at bits 0 and 32.
REQ-032 Hold valid high continuously: exactly one transfer per 512 clk, underrun never pulses, and sample_ready deasserts between loads.
REQ-033 Bypass case, valid first asserted exactly in a load cycle with holding empty: that pair is emitted in the same frame and underrun = 0.
REQ-034 Assert resetb low at bit_cnt 40: all outputs are 0 within the same clk; after release, transmission restarts from REQ-030 behaviour.
REQ-035 Drop ena for 3 clk mid-frame with holding full: holding is cleared and sample_ready = 0; after ena returns, the next frame underruns.
